// File: rtl/irq_claim_master.sv
// Wishbone master that claims PLIC interrupts, hands the ID to the core and writes completions.
// Optional ack timeout is enabled by defining IRQ_CLAIM_TIMEOUT_EN.
module irq_claim_master #(
  parameter logic [31:0] CLAIM_ADDR     = 32'h0000_0000,
  parameter logic [31:0] COMPLETE_ADDR  = 32'h0000_0004,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        plic_ext_irq_i,
  output logic        core_irq_valid_o,
  output logic [1:0]  core_irq_id_o,
  input  logic        core_irq_ready_i,
  input  logic        core_cmpl_valid_i,
  input  logic [1:0]  core_cmpl_id_i,
  output logic        core_cmpl_ready_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_wdata_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_rdata_i,
  input  logic        wbm_ack_i,
  output logic        err_o
);

  typedef enum logic [2:0] {StIdle, StClaim, StDeliver, StCmpl, StGap} state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [1:0]  id_q, id_d;
  logic        cmpl_ready_q, cmpl_ready_d;
  logic [1:0]  cmpl_id_q, cmpl_id_d;
  logic        gap_q, gap_d;
  logic        ack_hit;
  logic        timeout;
  logic        unused_rdata;

  assign unused_rdata = ^wbm_rdata_i[31:2];
  // Acks outside a bus cycle are stray and must not advance the FSM.
  assign ack_hit = wbm_ack_i & cyc_q;

`ifdef IRQ_CLAIM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  always_comb begin
    cnt_d = 8'd0;
    if ((state_d == StClaim || state_d == StCmpl) && state_d == state_q) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign timeout = (state_q == StClaim || state_q == StCmpl) && !ack_hit &&
                   (cnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    id_d         = id_q;
    cmpl_ready_d = 1'b0;
    cmpl_id_d    = cmpl_id_q;
    gap_d        = gap_q;

    unique case (state_q)
      StIdle: begin
        if (core_cmpl_valid_i) begin
          cmpl_id_d    = core_cmpl_id_i;
          cmpl_ready_d = 1'b1;
          state_d      = StCmpl;
        end else if (plic_ext_irq_i) begin
          state_d = StClaim;
        end
      end
      StClaim: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = CLAIM_ADDR;
        end else if (ack_hit || timeout) begin
          cyc_d   = 1'b0;
          addr_d  = 32'd0;
          state_d = StGap;
          // ID 0 from the claim register means nothing was pending.
          if (ack_hit && wbm_rdata_i[1:0] != 2'd0) begin
            valid_d = 1'b1;
            id_d    = wbm_rdata_i[1:0];
            state_d = StDeliver;
          end
        end
      end
      StCmpl: begin
        if (!cyc_q) begin
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = COMPLETE_ADDR;
          wdata_d = {30'd0, cmpl_id_q};
        end else if (ack_hit || timeout) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          state_d = StGap;
        end
      end
      StDeliver: begin
        if (core_irq_ready_i) begin
          valid_d = 1'b0;
          id_d    = 2'd0;
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = ~gap_q;
        if (gap_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      valid_q      <= 1'b0;
      id_q         <= 2'd0;
      cmpl_ready_q <= 1'b0;
      cmpl_id_q    <= 2'd0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      cmpl_ready_q <= cmpl_ready_d;
      cmpl_id_q    <= cmpl_id_d;
      gap_q        <= gap_d;
    end
  end

  assign wbm_cyc_o         = cyc_q;
  assign wbm_stb_o         = cyc_q;
  assign wbm_we_o          = we_q;
  assign wbm_addr_o        = addr_q;
  assign wbm_wdata_o       = wdata_q;
  assign wbm_sel_o         = {4{cyc_q}};
  assign core_irq_valid_o  = valid_q;
  assign core_irq_id_o     = id_q;
  assign core_cmpl_ready_o = cmpl_ready_q;

endmodule

// File: tb/tb_irq_claim_master.sv
// Directed bench for irq_claim_master: vector table for the main flows, hand sequences for
// reset-abort and the unacknowledged claim.
module tb_irq_claim_master;

  localparam logic [31:0] CA = 32'h0000_0000;
  localparam logic [31:0] PA = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst_n, irq, irq_valid, irq_ready, cmpl_valid, cmpl_ready;
  logic [1:0]  irq_id, cmpl_id;
  logic        cyc, stb, we, ack, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_claim_master #(
    .CLAIM_ADDR    (CA),
    .COMPLETE_ADDR (PA),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .plic_ext_irq_i   (irq),
    .core_irq_valid_o (irq_valid),
    .core_irq_id_o    (irq_id),
    .core_irq_ready_i (irq_ready),
    .core_cmpl_valid_i(cmpl_valid),
    .core_cmpl_id_i   (cmpl_id),
    .core_cmpl_ready_o(cmpl_ready),
    .wbm_cyc_o        (cyc),
    .wbm_stb_o        (stb),
    .wbm_we_o         (we),
    .wbm_addr_o       (addr),
    .wbm_wdata_o      (wdata),
    .wbm_sel_o        (sel),
    .wbm_rdata_i      (rdata),
    .wbm_ack_i        (ack),
    .err_o            (err)
  );

  typedef struct {
    logic        rst_n, irq, rdy, cv;
    logic [1:0]  cid;
    logic [31:0] rdata;
    logic        ack;
    logic        e_cyc, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_val;
    logic [1:0]  e_id;
    logic        e_cr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, i, rd, cv, input logic [1:0] cid, input logic [31:0] rda,
                     input logic a, ec, ew, input logic [31:0] ea, ewd, input logic ev,
                     input logic [1:0] eid, input logic ecr);
    vec_t v;
    v.rst_n = r; v.irq = i; v.rdy = rd; v.cv = cv; v.cid = cid; v.rdata = rda; v.ack = a;
    v.e_cyc = ec; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_val = ev; v.e_id = eid;
    v.e_cr = ecr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ec, ew, input logic [31:0] ea, ewd,
                         input logic ev, input logic [1:0] eid, input logic ecr);
    chk({tag, " cyc"}, 32'(cyc), 32'(ec));
    chk({tag, " stb"}, 32'(stb), 32'(ec));
    chk({tag, " we"}, 32'(we), 32'(ew));
    chk({tag, " addr"}, addr, ea);
    chk({tag, " wdata"}, wdata, ewd);
    chk({tag, " sel"}, 32'(sel), ec ? 32'hF : 32'h0);
    chk({tag, " valid"}, 32'(irq_valid), 32'(ev));
    chk({tag, " id"}, 32'(irq_id), 32'(eid));
    chk({tag, " cmpl_ready"}, 32'(cmpl_ready), 32'(ecr));
    chk({tag, " err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int errs;
    int cyc_hi;
    rst_n = 1'b0; irq = 1'b0; irq_ready = 1'b0; cmpl_valid = 1'b0; cmpl_id = 2'd0;
    rdata = 32'd0; ack = 1'b0;

    //  rst irq rdy cv cid rdata ack | cyc we addr wdata val id cr
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // reset
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // IDLE -> CLAIM
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, CA, 0, 0, 0, 0);  // claim read starts
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, CA, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2, 1,  0, 0, 0,  0, 1, 2, 0);  // ack id 2
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 2, 0);  // held until ready
    add(1, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // accepted -> GAP
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // irq ignored in GAP
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // GAP -> IDLE
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // IDLE -> CLAIM
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, CA, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);  // spurious id 0
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0);  // stray ack, cyc=0
    add(1, 0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1);  // completion id 1
    add(1, 0, 0, 0, 0, 0, 0,  1, 1, PA, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0, 1);  // both: completion wins
    add(1, 1, 0, 0, 0, 0, 0,  1, 1, PA, 2, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);  // then the claim
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, CA, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 1, 1, 0);
    add(1, 0, 0, 1, 2, 0, 0,  0, 0, 0,  0, 1, 1, 0);  // completion must wait
    add(1, 0, 1, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 0, 1);  // accepted back in IDLE
    add(1, 0, 0, 0, 0, 0, 0,  1, 1, PA, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);

    #2;
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst_n; irq = vecs[k].irq; irq_ready = vecs[k].rdy;
      cmpl_valid = vecs[k].cv; cmpl_id = vecs[k].cid; rdata = vecs[k].rdata; ack = vecs[k].ack;
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].e_cyc, vecs[k].e_we, vecs[k].e_addr,
              vecs[k].e_wdata, vecs[k].e_val, vecs[k].e_id, vecs[k].e_cr);
    end

    // Reset while the claim read waits for ack.
    irq = 1'b1; rdata = 32'd0; ack = 1'b0; irq_ready = 1'b0; cmpl_valid = 1'b0;
    tick();
    irq = 1'b0;
    tick();
    chk("rst_abort pre cyc", 32'(cyc), 32'h1);
    rst_n = 1'b0;
    tick();
    chk_all("rst_abort", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1; ack = 1'b1; rdata = 32'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      ack = 1'b0;
      chk_all($sformatf("rst_after%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    // Claim that is never acknowledged.
    irq = 1'b1;
    tick();
    irq = 1'b0;
    errs = 0;
    cyc_hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (err) errs++;
      if (cyc) cyc_hi++;
      if (irq_valid) errs += 100;
    end
`ifdef IRQ_CLAIM_TIMEOUT_EN
    chk("timeout err pulses", 32'(errs), 32'd1);
    chk("timeout cyc dropped", 32'(cyc), 32'h0);
`else
    chk("noack err pulses", 32'(errs), 32'd0);
    chk("noack cyc held", 32'(cyc_hi), 32'd10);
    ack = 1'b1; rdata = 32'd0;
    tick();
    ack = 1'b0;
    chk("noack late ack cyc", 32'(cyc), 32'h0);
`endif
    tick();
    tick();
    chk("final valid", 32'(irq_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_claim_master.md
IRQ_CLAIM_MASTER -- requirements
Module: irq_claim_master

Interface
REQ-001 Parameter CLAIM_ADDR, default 32'h0000_0000: Wishbone address of the PLIC claim (IRQ response) register.
REQ-002 Parameter COMPLETE_ADDR, default 32'h0000_0004: Wishbone address of the PLIC complete register.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum ack wait in cycles; range 2..255; used only with IRQ_CLAIM_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 plic_ext_irq_i  input  1  external interrupt request from the PLIC.
REQ-007 core_irq_valid_o  output  1  claimed interrupt ID is valid toward the core.
REQ-008 core_irq_id_o  output  2  claimed interrupt ID: 1 = uart, 2 = gpio.
REQ-009 core_irq_ready_i  input  1  core accepts the ID.
REQ-010 core_cmpl_valid_i  input  1  core requests completion of an ID.
REQ-011 core_cmpl_id_i  input  2  ID to complete.
REQ-012 core_cmpl_ready_o  output  1  completion request accepted; pulses for 1 cycle.
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone master controls.
REQ-014 wbm_addr_o  output  32  bus address.
REQ-015 wbm_wdata_o  output  32  write data.
REQ-016 wbm_sel_o  output  4  byte selects; always 4'hF during a cycle.
REQ-017 wbm_rdata_i  input  32  read data.
REQ-018 wbm_ack_i  input  1  transfer acknowledge.
REQ-019 err_o  output  1  ack-timeout pulse; only meaningful with IRQ_CLAIM_TIMEOUT_EN.

Function
REQ-020 The FSM SHALL have the states IDLE, CLAIM, DELIVER, CMPL and GAP; all outputs SHALL be registered.
REQ-021 In IDLE, a pending completion (core_cmpl_valid_i=1) SHALL take priority: latch core_cmpl_id_i, assert core_cmpl_ready_o for 1 cycle, then go to CMPL.
REQ-022 Otherwise, in IDLE with plic_ext_irq_i=1, the FSM SHALL go to CLAIM.
REQ-023 In CLAIM, the block SHALL drive cyc=stb=1, we=0 and addr=CLAIM_ADDR, starting the cycle after the state is entered.
REQ-024 In CMPL, the block SHALL drive cyc=stb=1, we=1, addr=COMPLETE_ADDR and wdata={30'b0, latched ID}.
REQ-025 On wbm_ack_i in CLAIM or CMPL, the block SHALL deassert cyc and stb on the next cycle.
REQ-026 On ack in CLAIM, the block SHALL capture wbm_rdata_i[1:0]: a non-zero value goes to DELIVER; zero is treated as spurious and goes to GAP with no delivery.
REQ-027 On ack in CMPL, the FSM SHALL go to GAP.
REQ-028 In DELIVER, core_irq_valid_o SHALL be 1 and core_irq_id_o SHALL be stable until core_irq_ready_i=1; valid then drops the next cycle and the FSM goes to GAP.
REQ-029 GAP SHALL last exactly 2 cycles with cyc=stb=0, then go to IDLE; plic_ext_irq_i is ignored during GAP so the PLIC's registered response can settle.
REQ-030 A core_cmpl_valid_i that arrives outside IDLE SHALL wait with core_cmpl_ready_o=0 until the FSM returns to IDLE.
REQ-031 When cyc=0, wbm_we_o, wbm_addr_o and wbm_wdata_o SHALL be 0.
REQ-032 ack received while cyc=0 SHALL be ignored.

Reset
REQ-033 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, including core_irq_id_o=2'b0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer: cyc and stb fall on the next edge, and no delivery or completion is reported.

Configuration
REQ-035 With IRQ_CLAIM_TIMEOUT_EN defined, an 8-bit counter SHALL count the cycles spent in CLAIM or CMPL.
REQ-036 With the macro defined, if the counter reaches TIMEOUT_CYCLES without an ack, the block SHALL drop cyc and stb, pulse err_o for 1 cycle and go to GAP; an aborted claim delivers nothing, and an aborted completion is not retried.
REQ-037 Without the macro, the block SHALL wait for ack indefinitely, err_o SHALL be tied 0, and the counter SHALL not exist.

Verification
REQ-038 Claim: plic_ext_irq_i=1; ack after 2 cycles with rdata=32'h2 -> read at CLAIM_ADDR, then core_irq_valid_o=1 with id=2, held until ready; then GAP of 2 cycles.
REQ-039 Spurious claim: claim ack with rdata=0 -> core_irq_valid_o never asserts; FSM returns to IDLE after GAP.
REQ-040 Complete: core_cmpl_valid_i=1 with id=1 in IDLE -> 1-cycle ready pulse; write to COMPLETE_ADDR with wdata=32'h1 and sel=4'hF.
REQ-041 Simultaneous events: plic_ext_irq_i and core_cmpl_valid_i both 1 in IDLE -> completion write first, then GAP, then claim read.
REQ-042 Reset: rst_n=0 while CLAIM is waiting for ack -> cyc=stb=0 on the next cycle, all outputs 0, no delivery.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES=4): no ack during CLAIM -> cyc drops after 4 cycles, err_o pulses once, no delivery; without the macro, cyc stays high.
